// File: rtl/rv32_wb_data_master.sv
// ---------------------------------------------------------------------------
// rv32_wb_data_master
//   Wishbone classic single-transfer master for CPU data accesses.
//
//   Any memory-stage request whose address bits [31:28] equal REGION_SEL is
//   sent as one Wishbone transfer. The pipeline is frozen (stall_o) until the
//   slave answers. A timeout aborts the transfer if the slave never answers.
//
//   Ports
//     clk_i, rst_n_i            clock, asynchronous active-low reset
//     req_valid_i/write/be/addr/wdata
//                               memory-stage request (lane-aligned data/be)
//     stall_o                   freeze pipeline while a transfer is pending
//     rdata_o                   read data of last completed load (0 on error)
//     rdata_valid_o             one-cycle pulse: transfer completed
//     bus_err_o                 one-cycle pulse: ended by err or timeout
//     wb_*                      Wishbone classic master interface
// ---------------------------------------------------------------------------
module rv32_wb_data_master #(
    parameter logic [3:0] REGION_SEL     = 4'h2,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter int         TIMEOUT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  berr_q, berr_d;
    logic                  stall;
    logic                  hit;
    logic                  xfer_end;

    assign hit = req_valid_i && (req_addr_i[31:28] == REGION_SEL);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        berr_d   = 1'b0;
        stall    = 1'b0;
        xfer_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall = hit;
                if (hit) begin
                    adr_d   = req_addr_i;
                    dat_d   = req_wdata_i;
                    we_d    = req_write_i;
                    sel_d   = req_write_i ? req_be_i : 4'hF;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // err has priority over ack; a timeout is treated as an err
                if (wb_err_i || (!wb_ack_i && cnt_q == TO_LAST)) begin
                    rdata_d  = '0;
                    berr_d   = 1'b1;
                    xfer_end = 1'b1;
                end else if (wb_ack_i) begin
                    if (!we_q) rdata_d = wb_dat_i;
                    xfer_end = 1'b1;
                end
                if (xfer_end) begin
                    cyc_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            // Inputs still hold the request just served; never relaunch it.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            berr_q   <= berr_d;
        end
    end

    // stall is combinational from the request; gate it so it is 0 in reset.
    assign stall_o       = rst_n_i & stall;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign bus_err_o     = berr_q;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign wb_we_o       = we_q;
    assign wb_sel_o      = sel_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;

endmodule
